// File: rtl/mmio_hub.sv
// mmio_hub: decoded MMIO register file with a shared-counter PWM bank and an
// ADC start/wait sequencer. Reads are registered with a hit flag so the top
// level can mux RAM and MMIO read data without contention.
module mmio_hub #(
  parameter logic [15:0] BASE_ADDR = 16'h8000,
  parameter int          NUM_PWM   = 4,
  parameter int          PWM_BITS  = 8,
  parameter int          ADC_BITS  = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                read_enable,
  input  logic                write_enable,
  input  logic [15:0]         address,
  input  logic [15:0]         write_data,
  output logic [15:0]         read_data,
  output logic                read_hit,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [ADC_BITS-1:0] adc_sample,
  output logic [NUM_PWM-1:0]  pwm_out
);

  localparam logic [4:0] OFF_CTL  = 5'h10;
  localparam logic [4:0] OFF_DATA = 5'h11;
  localparam logic [4:0] OFF_MODE = 5'h12;
  localparam logic [4:0] OFF_PRE  = 5'h13;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} adc_state_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [15:0] rel;
  logic [4:0]  off;
  logic        in_win, duty_hit, mapped;
  logic        wr, rd, ctl_wr, mode_wr, pre_wr, data_rd, ctl_rd;

  assign rel      = address - BASE_ADDR;
  assign in_win   = (rel[15:5] == 11'd0);
  assign off      = rel[4:0];
  assign duty_hit = in_win && !off[4] && ({1'b0, off[3:0]} < 5'(NUM_PWM));
  assign mapped   = duty_hit || (in_win && off[4] && (off[3:2] == 2'b00));

  // A write always wins over a simultaneous read; the read is simply dropped.
  assign wr      = write_enable && in_win;
  assign rd      = read_enable && !write_enable && mapped;
  assign ctl_wr  = wr && (off == OFF_CTL);
  assign mode_wr = wr && (off == OFF_MODE);
  assign pre_wr  = wr && (off == OFF_PRE);
  assign data_rd = rd && (off == OFF_DATA);
  assign ctl_rd  = rd && (off == OFF_CTL);

  // ---------------------------------------------------------------------------
  // ADC sequencer
  // ---------------------------------------------------------------------------
  adc_state_t          state, state_nxt;
  logic                busy, done_ok;
  logic                valid, overrun;
  logic [ADC_BITS-1:0] sample;
  logic [1:0]          mode;        // bit0 auto-route to DUTY[0], bit1 free-run
  logic [15:0]         prescale;

  assign done_ok = adc_done && (state == S_WAIT);

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Sequencer next state; adc_start and busy decode straight from the state.
  always_comb begin
    state_nxt = state;
    adc_start = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE:  if (ctl_wr) state_nxt = S_START;
      S_START: begin
        adc_start = 1'b1;
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (adc_done) state_nxt = mode[1] ? S_START : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sample capture and status flags; a new sample beats a same-edge clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample  <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (done_ok) sample <= adc_sample;
      if (done_ok)      valid <= 1'b1;
      else if (data_rd) valid <= 1'b0;
      if (done_ok && valid) overrun <= 1'b1;
      else if (ctl_rd)      overrun <= 1'b0;
    end
  end

  // MODE and PRESCALE control registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode     <= 2'b00;
      prescale <= 16'h0000;
    end else begin
      if (mode_wr) mode     <= write_data[1:0];
      if (pre_wr)  prescale <= write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM timebase: prescaler tick drives one counter shared by every channel
  // ---------------------------------------------------------------------------
  logic [15:0]         pre_cnt;
  logic [PWM_BITS-1:0] cnt;
  logic                tick, wrap, auto_ld;
  logic [PWM_BITS-1:0] auto_duty;

  assign tick      = (pre_cnt == prescale);
  assign wrap      = tick && (&cnt);
  assign auto_ld   = done_ok && mode[0];
  assign auto_duty = adc_sample[ADC_BITS-1 -: PWM_BITS];

  // Prescaler restarts on a PRESCALE write so a new rate starts from a clean count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else begin
      if (pre_wr || tick) pre_cnt <= '0;
      else                pre_cnt <= pre_cnt + 16'd1;
      if (tick) cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM lanes: programmed duty, shadow duty loaded at wrap, registered compare
  // ---------------------------------------------------------------------------
  logic [NUM_PWM-1:0][15:0] duty_rd;

  for (genvar i = 0; i < NUM_PWM; i++) begin : g_lane
    logic [PWM_BITS-1:0] duty_q, act_q;
    logic                out_q, sel;

    assign sel = duty_hit && (off[3:0] == 4'(i));

    // Duty update (ADC auto-route beats a CPU write on lane 0), shadow load
    // only at the counter wrap so a period is never cut short, then compare.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        duty_q <= '0;
        act_q  <= '0;
        out_q  <= 1'b0;
      end else begin
        if (auto_ld && (i == 0)) duty_q <= auto_duty;
        else if (wr && sel)      duty_q <= write_data[PWM_BITS-1:0];
        if (wrap) act_q <= duty_q;
        out_q <= (cnt < act_q);
      end
    end

    assign duty_rd[i] = sel ? 16'(duty_q) : 16'h0000;
    assign pwm_out[i] = out_q;
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [15:0] rd_val;

  // Read mux; duty lanes contribute zero unless their own offset is selected.
  always_comb begin
    rd_val = 16'h0000;
    for (int i = 0; i < NUM_PWM; i++) rd_val = rd_val | duty_rd[i];
    case (off)
      OFF_CTL:  rd_val = {13'd0, overrun, busy, valid};
      OFF_DATA: rd_val = 16'(sample);
      OFF_MODE: rd_val = {14'd0, mode};
      OFF_PRE:  rd_val = prescale;
      default:  ;
    endcase
  end

  // Registered read response; data returns to zero whenever there is no hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_hit  <= 1'b0;
      read_data <= 16'h0000;
    end else begin
      read_hit  <= rd;
      read_data <= rd ? rd_val : 16'h0000;
    end
  end

endmodule

// File: tb/tb_mmio_hub.sv
// Bench for mmio_hub: bus vector table, ADC sequencer sequences, a per-cycle
// PWM reference model and a randomized register-file scoreboard.
module tb_mmio_hub;
  localparam int NP = 4;

  logic        clock = 1'b0;
  logic        reset, read_enable, write_enable, adc_done;
  logic [15:0] address, write_data, read_data;
  logic        read_hit, adc_start;
  logic [9:0]  adc_sample;
  logic [3:0]  pwm_out;

  mmio_hub #(.BASE_ADDR(16'h8000), .NUM_PWM(NP), .PWM_BITS(8), .ADC_BITS(10)) dut (
    .clock(clock), .reset(reset), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data), .read_hit(read_hit),
    .adc_start(adc_start), .adc_done(adc_done), .adc_sample(adc_sample), .pwm_out(pwm_out)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int ecount;          // clock edges since reset released
  bit pwm_chk = 1'b0;

  always @(posedge clock or posedge reset)
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Duty history: the edge at which each duty value was committed.
  typedef struct { int ch; int e; int v; } wr_t;
  wr_t wlog[$];

  function automatic int duty_at(input int ch, input int s);
    int v = 0;
    foreach (wlog[j]) if (wlog[j].ch == ch && wlog[j].e < s) v = wlog[j].v;
    return v;
  endfunction

  // With PRESCALE=0 the counter equals edges mod 256; the output after edge k
  // reflects phase k-1 of a period whose duty was fixed at its start edge.
  function automatic logic [3:0] exp_pwm(input int k);
    logic [3:0] r = '0;
    int ph, s;
    if (k == 0) return r;
    ph = (k - 1) % 256;
    s  = k - 1 - ph;
    for (int c = 0; c < NP; c++) r[c] = (s > 0) && (ph < duty_at(c, s));
    return r;
  endfunction

  always @(negedge clock) if (pwm_chk) chk("pwm_out", pwm_out, exp_pwm(ecount));

  // One bus cycle, entered just after a falling edge; returns registered outputs.
  task automatic bus(input logic re, input logic we, input logic [15:0] a, input logic [15:0] wd,
                     input logic dn, input logic [9:0] smp, output logic hit, output logic [15:0] rd);
    int e = ecount + 1;
    read_enable = re; write_enable = we; address = a; write_data = wd;
    adc_done = dn; adc_sample = smp;
    if (we && a >= 16'h8000 && a < 16'h8000 + NP)
      wlog.push_back('{int'(a - 16'h8000), e, int'(wd[7:0])});
    @(negedge clock);
    hit = read_hit; rd = read_data;
    read_enable = 1'b0; write_enable = 1'b0; adc_done = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    logic h; logic [15:0] r;
    bus(1'b0, 1'b1, a, d, 1'b0, 10'h0, h, r);
  endtask

  task automatic rdc(input string nm, input logic [15:0] a, input logic [15:0] exp);
    logic h; logic [15:0] r;
    bus(1'b1, 1'b0, a, 16'h0, 1'b0, 10'h0, h, r);
    chk({nm, " hit"}, 32'(h), 32'd1);
    chk({nm, " data"}, 32'(r), 32'(exp));
  endtask

  task automatic done(input logic [9:0] smp);
    logic h; logic [15:0] r;
    bus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, smp, h, r);
  endtask

  typedef struct {
    logic re; logic we; logic [15:0] addr; logic [15:0] wd;
    logic hit; logic [15:0] data;
  } vec_t;
  vec_t tbl[21];

  initial begin
    logic h; logic [15:0] r;
    int hi, hi0, hi1, hi2, hi3, e;
    logic [7:0]  md[NP];
    logic [1:0]  mmode;
    logic [15:0] mpre;

    tbl[0]  = '{1'b0, 1'b1, 16'h8013, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'h8001, 16'h0040, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 16'h8001, 16'h0000, 1'b1, 16'h0040};
    tbl[3]  = '{1'b0, 1'b1, 16'h8002, 16'h1234, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 16'h8002, 16'h0000, 1'b1, 16'h0034};
    tbl[5]  = '{1'b0, 1'b0, 16'h8002, 16'h0000, 1'b0, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 16'h8004, 16'h0000, 1'b0, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 16'h8020, 16'h0000, 1'b0, 16'h0000};
    tbl[8]  = '{1'b1, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 16'h8010, 16'h0000, 1'b1, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 16'h8011, 16'h0000, 1'b1, 16'h0000};
    tbl[11] = '{1'b0, 1'b1, 16'h8012, 16'hFFFF, 1'b0, 16'h0000};
    tbl[12] = '{1'b1, 1'b0, 16'h8012, 16'h0000, 1'b1, 16'h0003};
    tbl[13] = '{1'b0, 1'b1, 16'h8012, 16'h0000, 1'b0, 16'h0000};
    tbl[14] = '{1'b1, 1'b1, 16'h8003, 16'h00FF, 1'b0, 16'h0000};
    tbl[15] = '{1'b1, 1'b0, 16'h8003, 16'h0000, 1'b1, 16'h00FF};
    tbl[16] = '{1'b1, 1'b0, 16'h8013, 16'h0000, 1'b1, 16'h0000};
    tbl[17] = '{1'b0, 1'b1, 16'h8014, 16'hBEEF, 1'b0, 16'h0000};
    tbl[18] = '{1'b1, 1'b0, 16'h8014, 16'h0000, 1'b0, 16'h0000};
    tbl[19] = '{1'b0, 1'b1, 16'h7FE0, 16'h1111, 1'b0, 16'h0000};
    tbl[20] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h0000};

    reset = 1'b1; read_enable = 1'b0; write_enable = 1'b0; adc_done = 1'b0;
    address = 16'h0; write_data = 16'h0; adc_sample = 10'h0;
    repeat (3) @(negedge clock);
    chk("rst pwm_out", 32'(pwm_out), 0);
    chk("rst read_hit", 32'(read_hit), 0);
    chk("rst read_data", 32'(read_data), 0);
    chk("rst adc_start", 32'(adc_start), 0);
    reset = 1'b0;
    wlog.delete();
    pwm_chk = 1'b1;

    // Bus vectors
    foreach (tbl[i]) begin
      bus(tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wd, 1'b0, 10'h0, h, r);
      chk($sformatf("vec%0d hit", i), 32'(h), 32'(tbl[i].hit));
      chk($sformatf("vec%0d data", i), 32'(r), 32'(tbl[i].data));
    end
    @(negedge clock);
    chk("hit drops", 32'(read_hit), 0);

    // PWM ch1 at 0x40: 64 high clocks in any 256-clock window
    repeat (300) @(negedge clock);
    hi = 0;
    repeat (256) begin @(negedge clock); hi += int'(pwm_out[1]); end
    chk("pwm1 highs", 32'(hi), 64);

    // Mid-period duty change on ch0, model checks it waits for the wrap
    repeat (77) @(negedge clock);
    wr(16'h8000, 16'h0080);
    repeat (600) @(negedge clock);

    // Single conversion
    wr(16'h8010, 16'h0000);
    chk("start pulse", 32'(adc_start), 1);
    rdc("ctl busy", 16'h8010, 16'h0002);
    chk("start width", 32'(adc_start), 0);
    wr(16'h8010, 16'h0000);
    chk("ctl wr in wait", 32'(adc_start), 0);
    done(10'h3FF);
    chk("no restart", 32'(adc_start), 0);
    rdc("ctl valid", 16'h8010, 16'h0001);
    rdc("data 3ff", 16'h8011, 16'h03FF);
    rdc("ctl cleared", 16'h8010, 16'h0000);
    done(10'h155);
    rdc("stray done data", 16'h8011, 16'h03FF);
    rdc("stray done ctl", 16'h8010, 16'h0000);

    // Free-run and overrun
    wr(16'h8012, 16'h0002);
    wr(16'h8010, 16'h0000);
    chk("fr start", 32'(adc_start), 1);
    repeat (2) @(negedge clock);
    chk("fr wait", 32'(adc_start), 0);
    done(10'h100);
    chk("fr restart", 32'(adc_start), 1);
    wr(16'h8012, 16'h0000);
    done(10'h200);
    rdc("ctl overrun", 16'h8010, 16'h0005);
    rdc("ctl ovr clr", 16'h8010, 16'h0001);
    rdc("data 200", 16'h8011, 16'h0200);
    rdc("ctl idle", 16'h8010, 16'h0000);

    // Same-edge set vs clear
    wr(16'h8010, 16'h0000);
    @(negedge clock);
    bus(1'b1, 1'b0, 16'h8011, 16'h0, 1'b1, 10'h0AB, h, r);
    chk("data rd+done hit", 32'(h), 1);
    chk("data rd+done old", 32'(r), 32'h0200);
    rdc("valid set wins", 16'h8010, 16'h0001);
    wr(16'h8010, 16'h0000);
    @(negedge clock);
    bus(1'b1, 1'b0, 16'h8010, 16'h0, 1'b1, 10'h0CD, h, r);
    chk("ctl rd+done old", 32'(r), 32'h0003);
    rdc("ovr set wins", 16'h8010, 16'h0005);
    rdc("ovr then clr", 16'h8010, 16'h0001);
    rdc("data cd", 16'h8011, 16'h00CD);

    // Auto-route to DUTY[0]
    wr(16'h8012, 16'h0001);
    wr(16'h8010, 16'h0000);
    @(negedge clock);
    e = ecount + 1;
    done(10'h2A5);
    wlog.push_back('{0, e, 'hA9});
    rdc("auto duty0", 16'h8000, 16'h00A9);
    wr(16'h8010, 16'h0000);
    @(negedge clock);
    e = ecount + 1;
    bus(1'b0, 1'b1, 16'h8000, 16'h0011, 1'b1, 10'h3FF, h, r);
    wlog.push_back('{0, e, 'hFF});
    rdc("auto beats cpu", 16'h8000, 16'h00FF);
    wr(16'h8012, 16'h0000);
    rdc("auto data", 16'h8011, 16'h03FF);
    rdc("auto ovr only", 16'h8010, 16'h0004);
    rdc("auto ctl clr", 16'h8010, 16'h0000);
    repeat (600) @(negedge clock);

    // Reset in the middle of a conversion
    pwm_chk = 1'b0;
    wr(16'h8010, 16'h0000);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid rst adc_start", 32'(adc_start), 0);
    chk("mid rst pwm_out", 32'(pwm_out), 0);
    chk("mid rst read_hit", 32'(read_hit), 0);
    chk("mid rst read_data", 32'(read_data), 0);
    @(negedge clock);
    reset = 1'b0;
    wlog.delete();
    pwm_chk = 1'b1;
    done(10'h111);
    rdc("post rst ctl", 16'h8010, 16'h0000);
    rdc("post rst data", 16'h8011, 16'h0000);
    rdc("post rst duty3", 16'h8003, 16'h0000);
    repeat (20) @(negedge clock);
    pwm_chk = 1'b0;

    // Prescaler: PRESCALE=2 stretches the period to 768 clocks
    wr(16'h8002, 16'h0040);
    wr(16'h8003, 16'h00FF);
    wr(16'h8013, 16'h0002);
    rdc("prescale rd", 16'h8013, 16'h0002);
    repeat (1700) @(negedge clock);
    hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0;
    repeat (768) begin
      @(negedge clock);
      hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]);
      hi2 += int'(pwm_out[2]); hi3 += int'(pwm_out[3]);
    end
    chk("pre duty0 zero", 32'(hi0 + hi1), 0);
    chk("pre duty 0x40", 32'(hi2), 192);
    chk("pre full scale", 32'(hi3), 765);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // Randomized register-file traffic against a scoreboard
    foreach (md[i]) md[i] = 8'h00;
    mmode = 2'b00; mpre = 16'h0000;
    for (int n = 0; n < 400; n++) begin
      logic re, we, ehit;
      logic [15:0] a, wd, off, edata;
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else a = 16'h8000 + 16'($urandom_range(0, 31));
      if (we && a == 16'h8010) a = 16'h8012;
      wd  = 16'($urandom);
      off = a - 16'h8000;
      ehit = 1'b0; edata = 16'h0000;
      if (re && !we && off < 32) begin
        if (off < NP)              begin ehit = 1'b1; edata = {8'h00, md[off]}; end
        else if (off == 16'h10 || off == 16'h11) ehit = 1'b1;
        else if (off == 16'h12)    begin ehit = 1'b1; edata = {14'd0, mmode}; end
        else if (off == 16'h13)    begin ehit = 1'b1; edata = mpre; end
      end
      bus(re, we, a, wd, 1'b0, 10'h0, h, r);
      chk($sformatf("rnd%0d hit a=%h", n, a), 32'(h), 32'(ehit));
      chk($sformatf("rnd%0d data a=%h", n, a), 32'(r), 32'(edata));
      if (we && off < NP)     md[off] = wd[7:0];
      if (we && off == 16'h12) mmode  = wd[1:0];
      if (we && off == 16'h13) mpre   = wd;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
